stack_access_sequencer: RTL and testbench
=========================================

Name: stack_access_sequencer

Overview:
- Multi-cycle controller for all stack traffic in the memory stage: PUSH/POP of 16-bit registers and 32-bit PC/flags frames (CALL, RET, INT, RTI).
- Owns the stack pointer.
- Splits each 32-bit frame into two 16-bit data-memory accesses.
- Holds Busy high so the hazard unit stalls the pipeline while a frame is in flight.

Parameters:
SP_INIT, 32'h000FFFFF, reset value of SP (empty-stack address, top of data memory)
ADDR_W, 32, address / SP width
DATA_W, 16, data-memory word width

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Req  in  1  start a stack operation (sampled only when Busy=0)
Op  in  2  00 push16, 01 pop16, 10 push32, 11 pop32
WrData  in  32  push data; push16 uses [15:0]
Busy  out  1  operation in progress; stall request to the pipeline
Done  out  1  one-cycle completion pulse
Fault  out  1  one-cycle pulse with Done when the operation was rejected
RdData  out  32  pop result, valid from the Done cycle until the next accepted Req
SP  out  32  current stack pointer
MemAddr  out  32  data-memory address
MemDataIn  out  16  data-memory write data
MemDataOut  in  16  data-memory read data (combinational read)
MemRead  out  1  data-memory read enable
MemWrite  out  1  data-memory write enable

Behaviour:
- Reset (synchronous, has priority over Req):
  - State IDLE, SP=SP_INIT, RdData=0.
  - Busy, Done, Fault, MemRead and MemWrite all 0.
  - MemDataIn=0; MemAddr=SP.
- States: IDLE, ACC0, ACC1, FINISH. Busy = (state != IDLE).
- IDLE:
  - Req=1: latch Op and WrData, evaluate the fault condition.
    - Fault -> FINISH with a fault flag set.
    - Otherwise -> ACC0.
  - Req while Busy=1 is ignored; it is not queued.
- Fault conditions, evaluated on the SP value at the acceptance cycle:
  - push16: SP==0
  - push32: SP<2
  - pop16: SP==SP_INIT (stack empty)
  - pop32: (SP_INIT-SP)<2
  - On fault: no memory access, SP unchanged, RdData unchanged.
- Push (access address = SP, then SP decrements by 1 at the end of the access cycle):
  - ACC0: MemWrite=1, MemAddr=SP.
    - push32 writes WrData[31:16] and goes to ACC1.
    - push16 writes WrData[15:0] and goes to FINISH.
  - ACC1 (push32 only): MemWrite=1, MemAddr=SP (already decremented), writes WrData[15:0], then FINISH.
- Pop (access address = SP+1, then SP increments by 1 at the end of the access cycle):
  - ACC0: MemRead=1, MemAddr=SP+1. Capture MemDataOut into RdData[15:0]; RdData[31:16] cleared to 0.
    - pop32 -> ACC1; pop16 -> FINISH.
  - ACC1: MemRead=1, MemAddr=SP+1. Capture into RdData[31:16].
  - Net layout: push32 followed by pop32 returns the identical 32-bit value.
- FINISH: Done=1 for one cycle (plus Fault=1 if faulted), then -> IDLE. A Req in FINISH is ignored.
- Latency from the Req acceptance edge to the Done cycle:
  - 16-bit op: 2 cycles
  - 32-bit op: 3 cycles
  - faulted op: 1 cycle
  - Back-to-back throughput: one op per (latency+1) cycles.
- Outside ACC0/ACC1: MemRead=MemWrite=0, MemAddr=SP, MemDataIn holds its last value.
- MemRead and MemWrite are never high together.
- SP arithmetic is mod 2^32. Fault checks guarantee no wrap in legal use.
- Reset mid-operation: abort immediately. A half-written frame is left in memory; SP returns to SP_INIT and Done is not pulsed.

Test Plan:
- Reset, then idle 3 cycles -> SP=000FFFFF; Busy, Done, MemRead and MemWrite all 0.
- push16 WrData=0000ABCD -> mem[000FFFFF]=ABCD; SP=000FFFFE; Done in cycle 2; Busy high cycles 1-2.
- push32 12345678 then pop32 -> writes mem[000FFFFF]=1234 and mem[000FFFFE]=5678; pop reads 000FFFFE then 000FFFFF; RdData=12345678; SP back to 000FFFFF; each op reaches Done in cycle 3.
- pop16 right after reset -> Fault=1 and Done=1 in cycle 1; no MemRead; SP unchanged; RdData=0.
- Req held high continuously with op push16 -> accepted once per 3 cycles; SP decreases by 1 per accepted op; no accept while Busy.
- Reset asserted in ACC1 of push32 -> next cycle IDLE, SP=000FFFFF, no Done; mem[000FFFFF] already written; a following pop16 faults.

Source files
------------

// File: rtl/stack_access_sequencer.sv
// Stack access sequencer: owns SP and turns push/pop of 16/32-bit values into
// one or two 16-bit data-memory accesses, holding Busy while a frame is in flight.
module stack_access_sequencer #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = 'h000F_FFFF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic [1:0]            Op,
  input  logic [2*DATA_W-1:0]   WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault,
  output logic [2*DATA_W-1:0]   RdData,
  output logic [ADDR_W-1:0]     SP,
  output logic [ADDR_W-1:0]     MemAddr,
  output logic [DATA_W-1:0]     MemDataIn,
  input  logic [DATA_W-1:0]     MemDataOut,
  output logic                  MemRead,
  output logic                  MemWrite
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FINISH} state_t;

  state_t                state, nstate;
  logic [1:0]            op_q;
  logic [2*DATA_W-1:0]   wd_q;
  logic                  flt_q;
  logic [ADDR_W-1:0]     sp_q;
  logic [2*DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]     mdin_q;
  logic                  fault_now, acc, is_pop, is32;

  assign is_pop = op_q[0];
  assign is32   = op_q[1];
  assign acc    = (state == ACC0) || (state == ACC1);

  // Reject frames that would wrap SP below 0 or pop past the empty mark.
  always_comb begin
    fault_now = 1'b0;
    case (Op)
      2'b00: fault_now = (sp_q == '0);
      2'b01: fault_now = (sp_q == SP_INIT);
      2'b10: fault_now = (sp_q < ADDR_W'(2));
      2'b11: fault_now = ((SP_INIT - sp_q) < ADDR_W'(2));
      default: fault_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= '0;
      wd_q   <= '0;
      flt_q  <= 1'b0;
      sp_q   <= SP_INIT;
      rd_q   <= '0;
      mdin_q <= '0;
    end else begin
      state  <= nstate;
      mdin_q <= MemDataIn;
      if (state == IDLE && Req) begin
        op_q  <= Op;
        wd_q  <= WrData;
        flt_q <= fault_now;
      end
      if (acc) begin
        sp_q <= is_pop ? sp_q + ADDR_W'(1) : sp_q - ADDR_W'(1);
        if (is_pop) begin
          if (state == ACC0) rd_q <= {{DATA_W{1'b0}}, MemDataOut};
          else               rd_q[2*DATA_W-1:DATA_W] <= MemDataOut;
        end
      end
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (Req) nstate = fault_now ? FINISH : ACC0;
      ACC0:    nstate = is32 ? ACC1 : FINISH;
      ACC1:    nstate = FINISH;
      FINISH:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Memory strobes are dropped during reset so an aborted frame stops at once.
  always_comb begin
    Busy      = (state != IDLE);
    Done      = (state == FINISH);
    Fault     = (state == FINISH) && flt_q;
    MemRead   = acc && is_pop && !Reset;
    MemWrite  = acc && !is_pop && !Reset;
    MemAddr   = (acc && is_pop) ? sp_q + ADDR_W'(1) : sp_q;
    MemDataIn = mdin_q;
    if (acc && !is_pop)
      MemDataIn = (state == ACC0 && is32) ? wd_q[2*DATA_W-1:DATA_W] : wd_q[DATA_W-1:0];
  end

  assign SP     = sp_q;
  assign RdData = rd_q;

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Randomized bench for stack_access_sequencer against a stack-level reference
// model (SP as a number, memory as an array, per-op latency from the op type).
module tb_stack_access_sequencer;
  localparam logic [31:0] INIT = 32'h000F_FFFF;

  logic        CLK = 1'b0, Reset = 1'b1, Req = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] WrData = '0;
  logic        Busy, Done, Fault, MemRead, MemWrite;
  logic [31:0] RdData, SP, MemAddr;
  logic [15:0] MemDataIn, MemDataOut;

  logic [15:0] mem  [0:1023];
  logic [15:0] emem [0:1023];
  logic [31:0] exp_sp, exp_rd;
  int npass = 0, ntot = 0;

  stack_access_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .Op(Op), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Fault(Fault), .RdData(RdData), .SP(SP),
    .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
    .MemRead(MemRead), .MemWrite(MemWrite)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MemWrite) mem[MemAddr[9:0]] <= MemDataIn;
  assign MemDataOut = mem[MemAddr[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] mrd(input logic [31:0] a);
    return emem[a[9:0]];
  endfunction

  // Reference: returns latency and fault, updates model SP/RdData/memory.
  task automatic model_op(input logic [1:0] op, input logic [31:0] d,
                          output int lat, output logic f);
    logic [31:0] a;
    a = exp_sp;
    f = 1'b0;
    case (op)
      2'b00: if (exp_sp == 0) f = 1'b1;
             else begin emem[a[9:0]] = d[15:0]; exp_sp = exp_sp - 1; end
      2'b10: if (exp_sp < 2) f = 1'b1;
             else begin
               emem[a[9:0]] = d[31:16]; a = a - 1; emem[a[9:0]] = d[15:0];
               exp_sp = exp_sp - 2;
             end
      2'b01: if (exp_sp == INIT) f = 1'b1;
             else begin exp_rd = {16'h0, mrd(exp_sp + 1)}; exp_sp = exp_sp + 1; end
      default: if (INIT - exp_sp < 2) f = 1'b1;
             else begin exp_rd = {mrd(exp_sp + 2), mrd(exp_sp + 1)}; exp_sp = exp_sp + 2; end
    endcase
    lat = f ? 1 : (op[1] ? 3 : 2);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] d);
    int elat, lat;
    logic ef;
    model_op(op, d, elat, ef);
    @(negedge CLK);
    chk("idle_busy", Busy, 0);
    Req = 1'b1; Op = op; WrData = d;
    @(posedge CLK);
    @(negedge CLK);
    Req = 1'b0;
    lat = 1;
    chk("busy_c1", Busy, 1);
    while (!Done && lat < 8) begin
      chk("rw_excl", MemRead & MemWrite, 0);
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, elat);
    chk("fault", Fault, ef);
    chk("sp", SP, exp_sp);
    chk("rddata", RdData, exp_rd);
    if (!ef && !op[0]) begin
      chk("mem_top", mem[exp_sp[9:0] + 10'd1], emem[exp_sp[9:0] + 10'd1]);
      if (op[1]) chk("mem_top2", mem[exp_sp[9:0] + 10'd2], emem[exp_sp[9:0] + 10'd2]);
    end
  endtask

  initial begin
    int dcount, el;
    logic ef;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; emem[i] = '0; end
    exp_sp = INIT; exp_rd = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_sp", SP, INIT);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_rw", {MemRead, MemWrite}, 0);
    chk("rst_rd", RdData, 0);
    chk("rst_addr", MemAddr, INIT);
    chk("rst_mdin", MemDataIn, 0);

    run_op(2'b01, 32'h0);            // pop16 on empty stack
    run_op(2'b00, 32'h0000_ABCD);
    chk("mem_abcd", mem[INIT[9:0]], 16'hABCD);
    run_op(2'b01, 32'h0);
    run_op(2'b10, 32'h1234_5678);
    run_op(2'b11, 32'h0);
    chk("pop32_val", RdData, 32'h1234_5678);
    run_op(2'b00, 32'h0000_5555);    // one word left: pop32 must fault
    run_op(2'b11, 32'h0);
    run_op(2'b01, 32'h0);

    for (int n = 0; n < 150; n++) run_op(2'($urandom_range(0, 3)), $urandom);

    // Req held high: one push16 accepted every 3 cycles
    @(negedge CLK);
    Req = 1'b1; Op = 2'b00; WrData = 32'h0000_BEEF;
    dcount = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      if (Done) dcount++;
    end
    Req = 1'b0;
    for (int k = 0; k < 3; k++) model_op(2'b00, 32'h0000_BEEF, el, ef);
    chk("hold_dones", dcount, 3);
    chk("hold_sp", SP, exp_sp);
    chk("hold_mem", mem[exp_sp[9:0] + 10'd1], 16'hBEEF);

    // Reset during ACC1 of push32
    @(negedge CLK) Reset = 1'b1;
    @(negedge CLK) Reset = 1'b0;
    exp_sp = INIT; exp_rd = '0;
    @(negedge CLK);
    Req = 1'b1; Op = 2'b10; WrData = 32'hCAFE_F00D;
    @(posedge CLK);
    @(negedge CLK) Req = 1'b0;
    @(negedge CLK);
    chk("acc1_wr", MemWrite, 1);
    Reset = 1'b1;
    @(negedge CLK) Reset = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_sp", SP, INIT);
    chk("abort_mem", mem[INIT[9:0]], 16'hCAFE);
    @(negedge CLK);
    chk("abort_nodone", Done, 0);
    run_op(2'b01, 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
